// File: rtl/simple_ctrl_pkg.sv
// Shared encodings for the simple_ctrl sequencer and its external ALU/shifter:
// phase enum, opcode fields, branch conditions, flag positions and decode helpers.
package simple_ctrl_pkg;

    // One-hot-free phase sequence; every instruction walks all five.
    typedef enum logic [2:0] {
        PH_FETCH  = 3'd0,
        PH_DECODE = 3'd1,
        PH_EXEC   = 3'd2,
        PH_MEM    = 3'd3,
        PH_WB     = 3'd4
    } phase_e;

    // op1 = IR[15:14]
    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_BR  = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    // op2 = IR[13:11] when op1 = OP1_BR
    localparam logic [2:0] OP2_LI  = 3'b000;
    localparam logic [2:0] OP2_B   = 3'b100;
    localparam logic [2:0] OP2_BCC = 3'b111;

    // op3 = IR[7:4] when op1 = OP1_ALU
    localparam logic [3:0] OP3_ADD = 4'b0000;
    localparam logic [3:0] OP3_SUB = 4'b0001;
    localparam logic [3:0] OP3_AND = 4'b0010;
    localparam logic [3:0] OP3_OR  = 4'b0011;
    localparam logic [3:0] OP3_XOR = 4'b0100;
    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_MOV = 4'b0110;
    localparam logic [3:0] OP3_SLL = 4'b1000;
    localparam logic [3:0] OP3_SLR = 4'b1001;
    localparam logic [3:0] OP3_SRL = 4'b1010;
    localparam logic [3:0] OP3_SRA = 4'b1011;
    localparam logic [3:0] OP3_IN  = 4'b1100;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    // Branch condition = IR[10:8] for Bcc
    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    // Flag bit positions inside the {S,Z,C,V} code
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Decoded control bits derived from IR
    typedef struct packed {
        logic ld;         // load word
        logic st;         // store word
        logic br;         // unconditional branch
        logic bcc;        // conditional branch
        logic wr_dr;      // write DR to R[IR[10:8]] in WB
        logic lat_dr;     // capture calc_result into DR in EXEC
        logic lat_flags;  // capture calc_code into FLAGS in EXEC
        logic in_op;      // write in_data to R[IR[10:8]] in WB
        logic out_op;     // drive out_data from R[IR[13:11]] in WB
        logic hlt;        // stop the machine in WB
    } dec_t;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    // Anything not listed decodes to all-zero controls, i.e. a NOP.
    function automatic dec_t decode_ir(input logic [15:0] ir);
        dec_t d;
        d = '0;
        case (ir[15:14])
            OP1_LD: d.ld = 1'b1;
            OP1_ST: d.st = 1'b1;
            OP1_BR: begin
                case (ir[13:11])
                    OP2_LI: begin
                        d.lat_dr = 1'b1;
                        d.wr_dr  = 1'b1;
                    end
                    OP2_B:   d.br  = 1'b1;
                    OP2_BCC: d.bcc = 1'b1;
                    default: d = '0;
                endcase
            end
            default: begin
                case (ir[7:4])
                    OP3_ADD, OP3_SUB, OP3_AND, OP3_OR, OP3_XOR, OP3_MOV,
                    OP3_SLL, OP3_SLR, OP3_SRL, OP3_SRA: begin
                        d.lat_dr    = 1'b1;
                        d.lat_flags = 1'b1;
                        d.wr_dr     = 1'b1;
                    end
                    OP3_CMP: begin
                        d.lat_dr    = 1'b1;
                        d.lat_flags = 1'b1;
                    end
                    OP3_IN:  d.in_op  = 1'b1;
                    OP3_OUT: d.out_op = 1'b1;
                    OP3_HLT: d.hlt    = 1'b1;
                    default: d = '0;
                endcase
            end
        endcase
        return d;
    endfunction

    // Evaluate a Bcc condition against the stored flags; unknown conds never branch.
    function automatic logic cond_holds(input logic [2:0] cond, input logic [3:0] flags);
        logic s_xor_v;
        logic taken;
        s_xor_v = flags[FLAG_S] ^ flags[FLAG_V];
        taken   = 1'b0;
        case (cond)
            COND_BE:  taken = flags[FLAG_Z];
            COND_BLT: taken = s_xor_v;
            COND_BLE: taken = flags[FLAG_Z] | s_xor_v;
            COND_BNE: taken = ~flags[FLAG_Z];
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/simple_ctrl_regfile8x16.sv
// Eight 16-bit general registers: two asynchronous read ports and one
// synchronous write port. Reads in the write cycle return the old value.
module regfile8x16
    import simple_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  raddr_a,
    output logic [15:0] rdata_a,
    input  logic [2:0]  raddr_b,
    output logic [15:0] rdata_b,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata
);

    logic [15:0] words [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            logic [15:0] word_q;
            logic [15:0] word_d;

            // Next value: take the write data only when this register is addressed.
            always_comb begin
                word_d = word_q;
                if (we && (waddr == 3'(gi))) begin
                    word_d = wdata;
                end
            end

            // Register storage, cleared by the asynchronous reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_q <= 16'h0000;
                end else begin
                    word_q <= word_d;
                end
            end

            assign words[gi] = word_q;
        end
    endgenerate

    assign rdata_a = words[raddr_a];
    assign rdata_b = words[raddr_b];

endmodule

// File: rtl/simple_ctrl.sv
// Five-phase instruction sequencer: fetch, decode, execute, memory, write-back.
// The ALU/shifter is external; this block owns PC, IR, DR, FLAGS and R0-R7.
module simple_ctrl
    import simple_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic [15:0] calc_instr,
    output logic [15:0] calc_a,
    output logic [15:0] calc_b,
    input  logic [15:0] calc_result,
    input  logic [3:0]  calc_code,
    input  logic [15:0] in_data,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        halted
);

    phase_e      phase_q, phase_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] dr_q, dr_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] ea_q, ea_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        halted_q, halted_d;

    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;

    dec_t        dec;
    logic        mem_access;

    assign dec        = decode_ir(ir_q);
    assign mem_access = (phase_q == PH_MEM) && (dec.ld || dec.st);

    // Port a reads the source field, port b the destination field.
    regfile8x16 u_rf (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (ir_q[13:11]),
        .rdata_a (rf_rdata_a),
        .raddr_b (ir_q[10:8]),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    // Phase sequencing, architectural state updates and register-file write control.
    always_comb begin
        phase_d     = phase_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        dr_d        = dr_q;
        flags_d     = flags_q;
        ea_d        = ea_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        halted_d    = halted_q;
        rf_we       = 1'b0;
        rf_waddr    = ir_q[10:8];
        rf_wdata    = dr_q;

        // Once halted, everything holds until reset.
        if (!halted_q) begin
            case (phase_q)
                PH_FETCH: begin
                    phase_d = PH_DECODE;
                end
                PH_DECODE: begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    phase_d = PH_EXEC;
                end
                PH_EXEC: begin
                    if (dec.lat_dr) begin
                        dr_d = calc_result;
                    end
                    if (dec.lat_flags) begin
                        flags_d = calc_code;
                    end
                    if (dec.ld || dec.st) begin
                        ea_d = rf_rdata_b + sext8(ir_q[7:0]);
                    end
                    phase_d = PH_MEM;
                end
                PH_MEM: begin
                    phase_d = PH_WB;
                end
                PH_WB: begin
                    phase_d = PH_FETCH;
                    if (dec.ld) begin
                        rf_we    = 1'b1;
                        rf_waddr = ir_q[13:11];
                        rf_wdata = mem_rdata;
                    end
                    if (dec.wr_dr) begin
                        rf_we = 1'b1;
                    end
                    if (dec.in_op) begin
                        rf_we    = 1'b1;
                        rf_wdata = in_data;
                    end
                    if (dec.out_op) begin
                        out_data_d  = rf_rdata_a;
                        out_valid_d = 1'b1;
                    end
                    // PC already points past the branch, so the offset is relative to that.
                    if (dec.br || (dec.bcc && cond_holds(ir_q[10:8], flags_q))) begin
                        pc_d = pc_q + sext8(ir_q[7:0]);
                    end
                    if (dec.hlt) begin
                        halted_d = 1'b1;
                        phase_d  = PH_WB;
                    end
                end
                default: begin
                    phase_d = PH_FETCH;
                end
            endcase
        end
    end

    // State register with asynchronous clear; a reset mid-instruction simply discards it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= PH_FETCH;
            pc_q        <= 16'h0000;
            ir_q        <= 16'h0000;
            dr_q        <= 16'h0000;
            flags_q     <= 4'h0;
            ea_q        <= 16'h0000;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            dr_q        <= dr_d;
            flags_q     <= flags_d;
            ea_q        <= ea_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

    // Memory and ALU-facing outputs decoded from the current phase.
    always_comb begin
        mem_addr   = mem_access ? ea_q : pc_q;
        mem_we     = (phase_q == PH_MEM) && dec.st && !halted_q;
        mem_wdata  = ((phase_q == PH_MEM) && dec.st) ? rf_rdata_a : 16'h0000;
        calc_instr = ((phase_q == PH_EXEC) || (phase_q == PH_MEM) || (phase_q == PH_WB))
                     ? ir_q : 16'h0000;
        calc_a     = rf_rdata_a;
        calc_b     = rf_rdata_b;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;

endmodule
